// File: rtl/mips_alu_md.sv
// MIPS-I integer execute unit: zero-latency ALU plus an iterative multiply/divide unit owning HI/LO.
// Optional macro ALU_MUL_FAST_EN: single-cycle combinational multiply; divide stays iterative.
module mips_alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func_code,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             ovf,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI = 6'h0F;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_MFHI = 6'h10, F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV = 6'h1A, F_DIVU = 6'h1B, F_ADD = 6'h20, F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t               state_reg;
    logic [SHW:0]         cnt_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     mag_reg;
    logic                 neg_q_reg;
    logic                 neg_r_reg;
    logic                 dbz_reg;
    logic [WIDTH-1:0]     dividend_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;

    // Decode of the HI/LO-owning instructions
    logic is_r, op_mult, op_div, op_mf, op_mthi, op_mtlo, md_op, signed_md;
    assign is_r      = (opcode == OP_RTYPE);
    assign op_mult   = is_r && (func_code == F_MULT || func_code == F_MULTU);
    assign op_div    = is_r && (func_code == F_DIV  || func_code == F_DIVU);
    assign op_mf     = is_r && (func_code == F_MFHI || func_code == F_MFLO);
    assign op_mthi   = is_r && (func_code == F_MTHI);
    assign op_mtlo   = is_r && (func_code == F_MTLO);
    assign md_op     = op_mult || op_div || op_mf || op_mthi || op_mtlo;
    assign signed_md = (func_code == F_MULT) || (func_code == F_DIV);

    assign busy  = (state_reg != S_IDLE);
    assign stall = valid_in && md_op && busy;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

    // Operand magnitudes and sign flags captured at issue
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign neg_a = signed_md && op1[WIDTH-1];
    assign neg_b = signed_md && op2[WIDTH-1];
    assign mag_a = neg_a ? -op1 : op1;
    assign mag_b = neg_b ? -op2 : op2;

    // Combinational ALU
    logic [WIDTH-1:0] sum, diff;
    logic             lt_s, lt_u;
    assign sum  = op1 + op2;
    assign diff = op1 - op2;
    assign lt_s = ($signed(op1) < $signed(op2));
    assign lt_u = (op1 < op2);

    always_comb begin
        alu_out = '0;
        ovf     = 1'b0;
        if (is_r) begin
            case (func_code)
                F_ADD: begin
                    alu_out = sum;
                    ovf     = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
                end
                F_ADDU: alu_out = sum;
                F_SUB: begin
                    alu_out = diff;
                    ovf     = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
                end
                F_SUBU: alu_out = diff;
                F_AND:  alu_out = op1 & op2;
                F_OR:   alu_out = op1 | op2;
                F_XOR:  alu_out = op1 ^ op2;
                F_NOR:  alu_out = ~(op1 | op2);
                F_SLT:  alu_out = {{(WIDTH-1){1'b0}}, lt_s};
                F_SLTU: alu_out = {{(WIDTH-1){1'b0}}, lt_u};
                F_SLL:  alu_out = op2 << shamt;
                F_SRL:  alu_out = op2 >> shamt;
                F_SRA:  alu_out = $signed(op2) >>> shamt;
                F_SLLV: alu_out = op2 << op1[SHW-1:0];
                F_SRLV: alu_out = op2 >> op1[SHW-1:0];
                F_SRAV: alu_out = $signed(op2) >>> op1[SHW-1:0];
                F_MFHI: alu_out = busy ? '0 : hi_reg;
                F_MFLO: alu_out = busy ? '0 : lo_reg;
                default: alu_out = '0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI: begin
                    alu_out = sum;
                    ovf     = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
                end
                OP_ADDIU: alu_out = sum;
                OP_SLTI:  alu_out = {{(WIDTH-1){1'b0}}, lt_s};
                OP_SLTIU: alu_out = {{(WIDTH-1){1'b0}}, lt_u};
                OP_ANDI:  alu_out = op1 & op2;
                OP_ORI:   alu_out = op1 | op2;
                OP_XORI:  alu_out = op1 ^ op2;
                OP_LUI:   alu_out = op2 << (WIDTH/2);
                default:  alu_out = '0;
            endcase
        end
    end

    assign zero = (alu_out == '0);

`ifdef ALU_MUL_FAST_EN
    logic [2*WIDTH-1:0] ext1, ext2, fast_product;
    assign ext1         = {{WIDTH{neg_a}}, op1};
    assign ext2         = {{WIDTH{neg_b}}, op2};
    assign fast_product = ext1 * ext2;
`else
    // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc_next, mul_result;
    assign mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mag_reg} : '0);
    assign mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    assign mul_result   = neg_q_reg ? -mul_acc_next : mul_acc_next;
`endif

    // Restoring-divide step: remainder in the upper half, dividend/quotient in the lower half
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_diff;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_rem_next, quo_final, rem_final;
    logic [2*WIDTH-1:0]   div_acc_next;
    assign div_shift    = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff     = {1'b0, div_shift} - {2'b00, mag_reg};
    assign div_ok       = !div_diff[WIDTH+1];
    assign div_rem_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_acc_next = {div_rem_next, acc_reg[WIDTH-2:0], div_ok};
    assign quo_final    = neg_q_reg ? -div_acc_next[WIDTH-1:0] : div_acc_next[WIDTH-1:0];
    assign rem_final    = neg_r_reg ? -div_acc_next[2*WIDTH-1:WIDTH] : div_acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            mag_reg      <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dbz_reg      <= 1'b0;
            dividend_reg <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (valid_in) begin
                        if (op_mthi) hi_reg <= op1;
                        if (op_mtlo) lo_reg <= op1;
                        if (op_mult) begin
                            state_reg <= S_MUL;
                            cnt_reg   <= '0;
                            neg_q_reg <= neg_a ^ neg_b;
`ifdef ALU_MUL_FAST_EN
                            acc_reg   <= fast_product;
`else
                            acc_reg   <= {{WIDTH{1'b0}}, mag_b};
                            mag_reg   <= mag_a;
`endif
                        end
                        if (op_div) begin
                            state_reg    <= S_DIV;
                            cnt_reg      <= '0;
                            acc_reg      <= {{WIDTH{1'b0}}, mag_a};
                            mag_reg      <= mag_b;
                            neg_q_reg    <= neg_a ^ neg_b;
                            neg_r_reg    <= neg_a;
                            dbz_reg      <= (op2 == '0);
                            dividend_reg <= op1;
                        end
                    end
                end
                S_MUL: begin
`ifdef ALU_MUL_FAST_EN
                    hi_reg    <= acc_reg[2*WIDTH-1:WIDTH];
                    lo_reg    <= acc_reg[WIDTH-1:0];
                    state_reg <= S_IDLE;
`else
                    acc_reg <= mul_acc_next;
                    if (cnt_reg == CNT_LAST) begin
                        hi_reg    <= mul_result[2*WIDTH-1:WIDTH];
                        lo_reg    <= mul_result[WIDTH-1:0];
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + (SHW+1)'(1);
                    end
`endif
                end
                S_DIV: begin
                    acc_reg <= div_acc_next;
                    if (cnt_reg == CNT_LAST) begin
                        // Divide by zero reports the raw dividend rather than the iteration result
                        hi_reg    <= dbz_reg ? dividend_reg : rem_final;
                        lo_reg    <= dbz_reg ? '1 : quo_final;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + (SHW+1)'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_md.sv
// Directed self-checking bench for mips_alu_md (WIDTH=32).
module tb_mips_alu_md;
    localparam int W = 32;
`ifdef ALU_MUL_FAST_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  func_code = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [31:0] alu_out, hi, lo;
    logic        zero, ovf, stall, busy;

    int tests_run = 0;
    int tests_failed = 0;

    mips_alu_md #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode),
        .func_code(func_code), .shamt(shamt), .op1(op1), .op2(op2),
        .alu_out(alu_out), .zero(zero), .ovf(ovf), .stall(stall),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  sa;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        exp_ovf;
    } vec_t;

    task automatic drive(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sa,
                         input logic [31:0] a, input logic [31:0] b);
        valid_in  = 1'b1;
        opcode    = opc;
        func_code = fn;
        shamt     = sa;
        op1       = a;
        op2       = b;
    endtask

    // Present a mult/div instruction for one edge; returns just after the issuing edge
    task automatic issue_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(6'h00, fn, 5'd0, a, b);
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL issue_stall fn=%h got=%b want=0", fn, stall);
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
        $display("[TB] issue fn=%h op1=%h op2=%h", fn, a, b);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset busy=%b hi=%h lo=%h stall=%b want 0/0/0/0", busy, hi, lo, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_alu();
        vec_t v[23];
        logic [31:0] got;
        v[0]  = '{6'h00, 6'h21, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        v[1]  = '{6'h00, 6'h20, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
        v[2]  = '{6'h00, 6'h22, 5'd0,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
        v[3]  = '{6'h00, 6'h23, 5'd0,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0};
        v[4]  = '{6'h00, 6'h2A, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
        v[5]  = '{6'h00, 6'h2B, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        v[6]  = '{6'h00, 6'h03, 5'd4,  32'h00000000, 32'h80000000, 32'hF8000000, 1'b0};
        v[7]  = '{6'h00, 6'h02, 5'd4,  32'h00000000, 32'h80000000, 32'h08000000, 1'b0};
        v[8]  = '{6'h00, 6'h00, 5'd31, 32'h00000000, 32'h00000001, 32'h80000000, 1'b0};
        v[9]  = '{6'h00, 6'h07, 5'd0,  32'h00000008, 32'h80000000, 32'hFF800000, 1'b0};
        v[10] = '{6'h00, 6'h04, 5'd9,  32'h00000024, 32'h0000000F, 32'h000000F0, 1'b0};
        v[11] = '{6'h0F, 6'h20, 5'd0,  32'h00000000, 32'h00001234, 32'h12340000, 1'b0};
        v[12] = '{6'h0C, 6'h00, 5'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        v[13] = '{6'h0D, 6'h00, 5'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0};
        v[14] = '{6'h00, 6'h26, 5'd0,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0};
        v[15] = '{6'h00, 6'h27, 5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        v[16] = '{6'h08, 6'h00, 5'd0,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1};
        v[17] = '{6'h09, 6'h00, 5'd0,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0};
        v[18] = '{6'h0A, 6'h00, 5'd0,  32'h00000005, 32'hFFFFFFFB, 32'h00000000, 1'b0};
        v[19] = '{6'h0B, 6'h00, 5'd0,  32'h00000005, 32'hFFFFFFFB, 32'h00000001, 1'b0};
        v[20] = '{6'h3F, 6'h20, 5'd0,  32'h00000001, 32'h00000002, 32'h00000000, 1'b0};
        v[21] = '{6'h00, 6'h01, 5'd0,  32'h00000001, 32'h00000002, 32'h00000000, 1'b0};
        v[22] = '{6'h00, 6'h22, 5'd0,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(v[i].opc, v[i].fn, v[i].sa, v[i].a, v[i].b);
            #1;
            got = alu_out;
            $display("[TB] alu vec %0d opc=%h fn=%h out=%h ovf=%b", i, v[i].opc, v[i].fn, got, ovf);
            tests_run++;
            if (got !== v[i].exp || ovf !== v[i].exp_ovf) begin
                tests_failed++;
                $display("[TB] FAIL alu_vec%0d got=%h/%b want=%h/%b", i, got, ovf, v[i].exp, v[i].exp_ovf);
            end
            tests_run++;
            if (zero !== (v[i].exp == 32'h0) || stall !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL alu_flags%0d zero=%b stall=%b want=%b/0", i, zero, stall, (v[i].exp == 32'h0));
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        issue_md(6'h18, 32'hFFFFFFFD, 32'h00000007);
        wait_idle(n);
        tests_run++;
        if (n != MUL_LAT || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            tests_failed++;
            $display("[TB] FAIL mult_neg cycles=%0d hi=%h lo=%h want %0d FFFFFFFF FFFFFFEB", n, hi, lo, MUL_LAT);
        end
        issue_md(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n);
        tests_run++;
        if (n != MUL_LAT || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            tests_failed++;
            $display("[TB] FAIL multu_max cycles=%0d hi=%h lo=%h want %0d FFFFFFFE 00000001", n, hi, lo, MUL_LAT);
        end
        @(negedge clk);
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        #1;
        tests_run++;
        if (alu_out !== 32'hFFFFFFFE || stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mfhi_idle got=%h stall=%b want=FFFFFFFE/0", alu_out, stall);
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic test_div();
        int n;
        issue_md(6'h1A, 32'hFFFFFFF9, 32'h00000002);
        wait_idle(n);
        tests_run++;
        if (n != W || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("[TB] FAIL div_neg cycles=%0d lo=%h hi=%h want 32 FFFFFFFD FFFFFFFF", n, lo, hi);
        end
        issue_md(6'h1B, 32'h00000005, 32'h00000000);
        wait_idle(n);
        tests_run++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'h00000005) begin
            tests_failed++;
            $display("[TB] FAIL divu_zero lo=%h hi=%h want FFFFFFFF 00000005", lo, hi);
        end
        issue_md(6'h1A, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        tests_run++;
        if (lo !== 32'h80000000 || hi !== 32'h00000000) begin
            tests_failed++;
            $display("[TB] FAIL div_ovf lo=%h hi=%h want 80000000 00000000", lo, hi);
        end
        issue_md(6'h1B, 32'd100, 32'd7);
        wait_idle(n);
        tests_run++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            tests_failed++;
            $display("[TB] FAIL divu_100_7 lo=%h hi=%h want 0000000e 00000002", lo, hi);
        end
        issue_md(6'h1A, 32'd7, 32'hFFFFFFFE);
        wait_idle(n);
        tests_run++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin
            tests_failed++;
            $display("[TB] FAIL div_pos_neg lo=%h hi=%h want FFFFFFFD 00000001", lo, hi);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int n_stall;
        int exp_st;
        exp_st = (MUL_LAT > 2) ? MUL_LAT - 2 : 0;
        // MFLO three cycles after MULT 2*3
        issue_md(6'h18, 32'd2, 32'd3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        drive(6'h00, 6'h12, 5'd0, 32'h0, 32'h0);
        #1;
        n_stall = 0;
        while (stall === 1'b1 && n_stall < 200) begin
            tests_run++;
            if (alu_out !== 32'h0 || lo !== 32'hFFFFFFFD) begin
                tests_failed++;
                $display("[TB] FAIL mflo_stalled out=%h lo=%h want 00000000 FFFFFFFD", alu_out, lo);
            end
            n_stall++;
            @(negedge clk);
            #1;
        end
        $display("[TB] mflo stalled %0d cycles out=%h", n_stall, alu_out);
        tests_run++;
        if (n_stall != exp_st || alu_out !== 32'd6) begin
            tests_failed++;
            $display("[TB] FAIL mflo_after stalls=%0d out=%h want %0d 00000006", n_stall, alu_out, exp_st);
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
        // Second MULT presented while the first is running must be ignored
        issue_md(6'h19, 32'd4, 32'd5);
        @(negedge clk);
        drive(6'h00, 6'h18, 5'd0, 32'd100, 32'd100);
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mult_busy_stall got=%b want=1", stall);
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
        wait_idle(n);
        tests_run++;
        if (lo !== 32'd20 || hi !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL mult_ignored lo=%h hi=%h want 00000014 00000000", lo, hi);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL no_restart busy=%b want=0", busy);
        end
    endtask

    task automatic test_reset_mid_div();
        issue_md(6'h1B, 32'd1000, 32'd7);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL div_running busy=%b want=1", busy);
        end
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset mid-div busy=%b hi=%h lo=%h", busy, hi, lo);
        tests_run++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_div busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(6'h00, 6'h11, 5'd0, 32'hA5A5A5A5, 32'h0);
        @(posedge clk);
        #1;
        drive(6'h00, 6'h13, 5'd0, 32'h00003C3C, 32'h0);
        tests_run++;
        if (hi !== 32'hA5A5A5A5 || lo !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL mthi hi=%h lo=%h want A5A5A5A5 00000000", hi, lo);
        end
        @(posedge clk);
        #1;
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        #1;
        tests_run++;
        if (lo !== 32'h00003C3C || alu_out !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("[TB] FAIL mtlo_mfhi lo=%h out=%h want 00003C3C A5A5A5A5", lo, alu_out);
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mips_alu_md.md
Name: mips_alu_md

Overview:
- Parametrised next-generation integer execute unit for the MIPS core.
- Covers all MIPS-I R-type and I-type ALU instructions combinationally.
- Adds an iterative multiply/divide unit that owns the HI and LO registers.
- Sits in EX. Decode supplies opcode and func_code unchanged, plus op2 already sign- or zero-extended. Control uses stall to hold the pipeline.

Parameters:
- WIDTH, 32, datapath width; even, at least 8.
- SHW, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  instruction present in EX this cycle
- opcode  in  6  instruction bits [31:26]
- func_code  in  6  instruction bits [5:0]; ignored when opcode != 0
- shamt  in  SHW  instruction shamt field
- op1  in  WIDTH  rs value
- op2  in  WIDTH  rt value or extended immediate
- alu_out  out  WIDTH  result
- zero  out  1  alu_out == 0
- ovf  out  1  signed overflow on ADD/ADDI/SUB
- stall  out  1  hold EX; instruction not accepted
- busy  out  1  mult/div in progress
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE, busy=0, hi=0, lo=0, counter=0. Combinational outputs follow inputs.
- Combinational ops, zero latency:
  - ADD, ADDU, ADDI, ADDIU: op1+op2.
  - SUB, SUBU: op1-op2.
  - AND/ANDI, OR/ORI, XOR/XORI, NOR.
  - SLT/SLTI: signed compare; SLTU/SLTIU: unsigned compare; result 0 or 1.
  - SLL/SRL/SRA: shift by shamt. SLLV/SRLV/SRAV: shift by op1[SHW-1:0].
  - LUI: op2 << WIDTH/2.
- ovf=1 only for ADD, ADDI or SUB with signed overflow; alu_out still carries the wrapped sum.
- Unknown or unlisted opcode/func_code: alu_out=0, ovf=0, stall=0. Never X.
- MFHI/MFLO: alu_out=hi or lo. If busy, stall=1 and alu_out=0.
- MTHI/MTLO (valid_in, !busy): load op1 into hi or lo at the clock edge. If busy, stall=1 and no write.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL on valid_in & (MULT|MULTU).
  - IDLE→DIV on valid_in & (DIV|DIVU).
  - Operands are latched at issue (magnitudes plus sign flags for signed ops).
  - A WIDTH-cycle shift-add or restoring-subtract iteration follows, using a counter of SHW+1 bits.
  - On the last count the FSM returns to IDLE and writes hi/lo on that edge.
  - Latency: issue at edge N, busy=1 for edges N+1..N+WIDTH, new hi/lo visible after edge N+WIDTH, busy=0 in the same cycle.
- MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed or unsigned.
- DIV/DIVU: lo=quotient, hi=remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: lo = all ones, hi = op1. No exception.
- Signed overflow (DIV of MIN by -1): lo=MIN, hi=0.
- MULT/DIV/MTHI/MTLO/MFHI/MFLO issued while busy: stall=1 and ignored. Upstream re-presents the instruction until stall=0.
- Mid-operation reset: operation aborted, hi/lo=0.
- valid_in=0: no state change and stall=0.

Optional Feature:
- Macro: ALU_MUL_FAST_EN.
- Defined: MULT/MULTU compute the product combinationally and register it into hi/lo at edge N+1. busy is high for exactly that one cycle. DIV timing is unchanged.
- Undefined: multiply uses the WIDTH-cycle iteration described above.

Test Plan:
- ADDU 0xFFFFFFFF+1 → alu_out=0, zero=1, ovf=0. ADD 0x7FFFFFFF+1 → alu_out=0x80000000, ovf=1.
- SLT op1=0xFFFFFFFF, op2=1 → 1. SLTU with the same operands → 0. SRA 0x80000000 by shamt=4 → 0xF8000000. LUI op2=0x1234 → 0x12340000.
- MULT op1=-3, op2=7 → busy for 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. With ALU_MUL_FAST_EN → same values after 1 cycle.
- DIV op1=-7, op2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU op1=5, op2=0 → lo=0xFFFFFFFF, hi=5.
- MFLO issued 3 cycles after MULT → stall=1 until busy falls, then alu_out=lo. A second MULT issued while busy → stall, hi/lo unchanged by it.
- rst_n pulsed low mid-DIV → busy=0, hi=lo=0 immediately. A following MTHI 0xA5A5A5A5 → hi=0xA5A5A5A5.
